// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, single-entry output register and valid/ready handoff.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra ParityError pulse output.
module uart_receiver #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FramingError,
    output logic       Overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       ParityError
`endif
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int SampleTime     = SymbolEdgeTime / 2;
    localparam int CntW           = $clog2(SymbolEdgeTime + 1);
    localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
    localparam logic [CntW-1:0] EdgeLast   = CntW'(SymbolEdgeTime - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state, stateNext;
    logic            sync1, sIn;
    logic [CntW-1:0] cycleCnt;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            cntClr, cntInc, dataTick, goodFrame, frameErr;
`ifdef UART_RX_PARITY_EN
    logic            parTick, parErr, parityBad;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        dataTick  = 1'b0;
        goodFrame = 1'b0;
        frameErr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parTick   = 1'b0;
        parErr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cntClr = 1'b1;
                if (!sIn) stateNext = START;
            end
            START: begin
                // Re-check the line half a bit in to reject glitches.
                if (cycleCnt == SampleLast) begin
                    cntClr    = 1'b1;
                    stateNext = sIn ? IDLE : DATA;
                end else cntInc = 1'b1;
            end
            DATA: begin
                if (cycleCnt == EdgeLast) begin
                    cntClr   = 1'b1;
                    dataTick = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bitCnt == 3'd7) stateNext = PARITY;
`else
                    if (bitCnt == 3'd7) stateNext = STOP;
`endif
                end else cntInc = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cycleCnt == EdgeLast) begin
                    cntClr    = 1'b1;
                    parTick   = 1'b1;
                    stateNext = STOP;
                end else cntInc = 1'b1;
            end
`endif
            STOP: begin
                if (cycleCnt == EdgeLast) begin
                    cntClr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    parErr = parityBad;
                    goodFrame = sIn && !parityBad;
`else
                    goodFrame = sIn;
`endif
                    frameErr  = !sIn;
                    stateNext = sIn ? IDLE : WAIT_HIGH;
                end else cntInc = 1'b1;
            end
            WAIT_HIGH: begin
                if (sIn) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1        <= 1'b1;
            sIn          <= 1'b1;
            cycleCnt     <= '0;
            bitCnt       <= '0;
            shiftReg     <= '0;
            DataOut      <= '0;
            DataOutValid <= 1'b0;
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad    <= 1'b0;
            ParityError  <= 1'b0;
`endif
        end else begin
            sync1 <= SIn;
            sIn   <= sync1;
            if (cntClr)      cycleCnt <= '0;
            else if (cntInc) cycleCnt <= cycleCnt + 1'b1;
            if (state == IDLE) bitCnt <= '0;
            if (dataTick) begin
                shiftReg <= {sIn, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (parTick) parityBad <= ^{shiftReg, sIn};
            ParityError <= parErr;
`endif
            FramingError <= frameErr;
            Overrun      <= 1'b0;
            if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
            // A transfer in the same cycle frees the register for the new byte.
            if (goodFrame) begin
                if (!DataOutValid || DataOutReady) begin
                    DataOut      <= shiftReg;
                    DataOutValid <= 1'b1;
                end else Overrun <= 1'b1;
            end
        end
    end

endmodule
